// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Purpose  : Serial pattern transmitter. Accepts a bit pattern of
//            programmable length and repeat count through a valid/ready
//            load handshake, then shifts it out MSB-first, one bit per clk.
//            Meant to feed the single-bit stream of a sequence detector.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            load_valid/ready  - load handshake (ready is combinational)
//            load_pattern      - pattern, bits [len-1:0] used
//            load_len          - length in bits, clamped to MAX_LEN
//            load_repeat       - pass count, 0 treated as 1
//            abort             - cancel transmission in progress
//            ser_bit/ser_valid - serial stream (ser_bit is 0 when not valid)
//            busy              - high while shifting or in an inter-pass gap
//            done              - one-cycle pulse after the final bit
// Config   : define SEQ_TX_GAP_EN to insert GAP_BITS valid zero bits between
//            consecutive passes (GAP_BITS=0 gives back-to-back passes).
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5,
  parameter int CNT_W    = 8,
  parameter int GAP_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [MAX_LEN-1:0] load_pattern,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [CNT_W-1:0]   load_repeat,
  input  logic               abort,
  output logic               ser_bit,
  output logic               ser_valid,
  output logic               busy,
  output logic               done
);

  localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);

`ifdef SEQ_TX_GAP_EN
  localparam int c_GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam bit c_GAP_ON = (GAP_BITS > 0);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;
  logic [c_GAP_W-1:0] r_gap_cnt;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
  } state_t;
  // GAP_BITS has no effect in this build.
  logic w_unused_gap;
  assign w_unused_gap = (GAP_BITS != 0);
`endif

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat;      // pattern, left-aligned so the first bit is the MSB
  logic [MAX_LEN-1:0] r_shift;    // bits still to send in the current pass
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_bit_cnt;  // bits remaining after the one on ser_bit
  logic [CNT_W-1:0]   r_rep_cnt;  // passes remaining, including the current one

  logic [LEN_W-1:0]   w_len;
  logic [MAX_LEN-1:0] w_aligned;
  logic [CNT_W-1:0]   w_rep;
  logic               w_accept;

  assign load_ready = (r_state == S_IDLE) && !reset;
  assign w_accept   = load_valid && load_ready;
  assign w_len      = (load_len > c_MAX_LEN) ? c_MAX_LEN : load_len;
  // Left-align so shifting out the MSB walks pattern[len-1] down to pattern[0];
  // bits above len fall off the top.
  assign w_aligned  = load_pattern << (c_MAX_LEN - w_len);
  assign w_rep      = (load_repeat == '0) ? CNT_W'(1) : load_repeat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_shift   <= '0;
      r_len     <= '0;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_TX_GAP_EN
      r_gap_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_len == '0) begin
              done <= 1'b1;
            end else begin
              r_state   <= S_SHIFT;
              r_pat     <= w_aligned;
              r_shift   <= w_aligned << 1;
              r_len     <= w_len;
              r_bit_cnt <= w_len - LEN_W'(1);
              r_rep_cnt <= w_rep;
              ser_bit   <= w_aligned[MAX_LEN-1];
              ser_valid <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (abort) begin
            r_state   <= S_IDLE;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (r_bit_cnt != '0) begin
            ser_bit   <= r_shift[MAX_LEN-1];
            r_shift   <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt - LEN_W'(1);
          end else if (r_rep_cnt > CNT_W'(1)) begin
            r_rep_cnt <= r_rep_cnt - CNT_W'(1);
`ifdef SEQ_TX_GAP_EN
            if (c_GAP_ON) begin
              r_state   <= S_GAP;
              ser_bit   <= 1'b0;
              r_gap_cnt <= c_GAP_W'(GAP_BITS - 1);
            end else begin
              ser_bit   <= r_pat[MAX_LEN-1];
              r_shift   <= r_pat << 1;
              r_bit_cnt <= r_len - LEN_W'(1);
            end
`else
            // Next pass starts immediately: no bubble.
            ser_bit   <= r_pat[MAX_LEN-1];
            r_shift   <= r_pat << 1;
            r_bit_cnt <= r_len - LEN_W'(1);
`endif
          end else begin
            r_state   <= S_IDLE;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

`ifdef SEQ_TX_GAP_EN
        S_GAP: begin
          if (abort) begin
            r_state   <= S_IDLE;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
          end else begin
            r_state   <= S_SHIFT;
            ser_bit   <= r_pat[MAX_LEN-1];
            r_shift   <= r_pat << 1;
            r_bit_cnt <= r_len - LEN_W'(1);
          end
        end
`endif

        default: begin
          r_state   <= S_IDLE;
          ser_bit   <= 1'b0;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Purpose  : Self-checking bench for seq_pattern_tx. Directed loads push
//            hand-computed expected stream events (bits and done pulses)
//            into a queue; a monitor pops and compares them as the DUT emits
//            them. A small 1011 detector model watches the serial stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_pattern;
  logic [4:0]  load_len;
  logic [7:0]  load_repeat;
  logic        abort;
  logic        ser_bit;
  logic        ser_valid;
  logic        busy;
  logic        done;

  seq_pattern_tx dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_len     (load_len),
    .load_repeat  (load_repeat),
    .abort        (abort),
    .ser_bit      (ser_bit),
    .ser_valid    (ser_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    bit val;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  det_cnt = 0;
  logic [2:0] det_hist = 3'b000;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_bits(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      ev_t e;
      c = s[i];
      e.is_done = 1'b0;
      e.val     = (c == 8'h31);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_done();
    ev_t e;
    e.is_done = 1'b1;
    e.val     = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered just after a posedge; returns just after the acceptance edge.
  task automatic load(input logic [15:0] p, input logic [4:0] l, input logic [7:0] r);
    int n = 0;
    while (!load_ready && n < 50) begin
      next_cycle();
      n++;
    end
    cmp("load_ready before load", load_ready, 1'b1);
    load_valid   = 1'b1;
    load_pattern = p;
    load_len     = l;
    load_repeat  = r;
    next_cycle();
    load_valid   = 1'b0;
    load_pattern = $urandom;
    load_len     = 5'($urandom);
    load_repeat  = 8'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < bound) begin
      next_cycle();
      n++;
    end
    cmp("idle within bound", (n < bound), 1'b1);
    next_cycle();
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    ev_t e;
    if (ser_valid) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected ser_valid", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        cmp("stream event is bit", e.is_done, 1'b0);
        cmp("ser_bit", ser_bit, e.val);
      end
    end else begin
      cmp("ser_bit idle zero", ser_bit, 1'b0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected done", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        cmp("stream event is done", e.is_done, 1'b1);
      end
    end
  end

  // Downstream 1011 detector model (sees ser_bit, which is 0 when idle).
  always @(negedge clk) begin
    if ({det_hist, ser_bit} == 4'b1011) det_cnt++;
    det_hist = {det_hist[1:0], ser_bit};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int exp_rep3;
    reset        = 1'b1;
    load_valid   = 1'b0;
    load_pattern = '0;
    load_len     = '0;
    load_repeat  = '0;
    abort        = 1'b0;
    next_cycle();
    next_cycle();
    cmp("reset ser_valid", ser_valid, 1'b0);
    cmp("reset busy", busy, 1'b0);
    cmp("reset done", done, 1'b0);
    cmp("load_ready in reset", load_ready, 1'b0);
    reset = 1'b0;
    #1;
    cmp("load_ready after reset", load_ready, 1'b1);
    next_cycle();

    // 1: 1011, len 4, repeat 1 -> bits in cycles 1-4, done in cycle 5.
    push_bits("1011");
    push_done();
    load(16'h000B, 5'd4, 8'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cmp("t1 ser_valid cycle", ser_valid, 1'b1);
      cmp("t1 busy cycle", busy, 1'b1);
    end
    @(negedge clk);
    cmp("t1 done cycle5", done, 1'b1);
    cmp("t1 busy cycle5", busy, 1'b0);
    cmp("t1 load_ready cycle5", load_ready, 1'b1);
    next_cycle();
    cmp("t1 detector count", det_cnt, 1);

    // 2: repeat 3 -> contiguous valid run, then done.
`ifdef SEQ_TX_GAP_EN
    push_bits("1011001011001011");
    exp_rep3 = 16;
`else
    push_bits("101110111011");
    exp_rep3 = 12;
`endif
    push_done();
    load(16'h000B, 5'd4, 8'd3);
    cnt = 0;
    @(negedge clk);
    while (ser_valid && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    cmp("t2 contiguous valid bits", cnt, exp_rep3);
    cmp("t2 done after run", done, 1'b1);
    wait_idle(100);
    cmp("t2 detector count", det_cnt, 4);

    // 3a: len 0 -> done in cycle 1, nothing sent.
    push_done();
    load(16'hFFFF, 5'd0, 8'd5);
    @(negedge clk);
    cmp("t3 len0 done", done, 1'b1);
    cmp("t3 len0 busy", busy, 1'b0);
    cmp("t3 len0 ser_valid", ser_valid, 1'b0);
    wait_idle(50);

    // 3b: len 20 clamped to 16.
    push_bits("1100001110100101");
    push_done();
    load(16'hC3A5, 5'd20, 8'd1);
    wait_idle(100);

    // 4: abort in cycle 3 of A5 -> cycle 4 idle, new load accepted in cycle 4.
    push_bits("101");
    load(16'h00A5, 5'd8, 8'd1);
    next_cycle();
    next_cycle();
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    cmp("t4 abort ser_valid", ser_valid, 1'b0);
    cmp("t4 abort busy", busy, 1'b0);
    cmp("t4 abort done", done, 1'b0);
    push_bits("0110");
    push_done();
    load(16'h0006, 5'd4, 8'd0);
    wait_idle(100);

    // Abort on the final bit: no done pulse.
    push_bits("10");
    load(16'h0002, 5'd2, 8'd1);
    next_cycle();
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    cmp("abort-final done", done, 1'b0);
    cmp("abort-final ser_valid", ser_valid, 1'b0);
    next_cycle();
    cmp("abort-final done later", done, 1'b0);
    wait_idle(50);

    // Load presented with abort while IDLE is accepted.
    push_bits("11");
    push_done();
    abort = 1'b1;
    load(16'h0003, 5'd2, 8'd1);
    abort = 1'b0;
    wait_idle(50);

    // 5: reset in cycle 2 of a transmission.
    push_bits("11");
    load(16'hFFFF, 5'd8, 8'd2);
    next_cycle();
    reset = 1'b1;
    #1;
    cmp("t5 load_ready during reset", load_ready, 1'b0);
    next_cycle();
    cmp("t5 ser_valid after reset", ser_valid, 1'b0);
    cmp("t5 busy after reset", busy, 1'b0);
    cmp("t5 done after reset", done, 1'b0);
    cmp("t5 load_ready reset high", load_ready, 1'b0);
    reset = 1'b0;
    #1;
    cmp("t5 load_ready reset low", load_ready, 1'b1);
    wait_idle(50);

    // 6: repeat 2 with or without gap.
`ifdef SEQ_TX_GAP_EN
    push_bits("1011001011");
`else
    push_bits("10111011");
`endif
    push_done();
    load(16'h000B, 5'd4, 8'd2);
    wait_idle(100);
    cmp("t6 detector count", det_cnt, 6);

    // Maximum repeat count is sent in full.
    for (int i = 0; i < 255; i++) push_bits("1");
    push_done();
    load(16'h0001, 5'd1, 8'd255);
    wait_idle(600);

    cmp("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
